// File: rtl/acc_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit accumulator core: sequences IDLE/FETCH/DECODE/EXEC/WB/HALT.
// Define ACC_CTRL_ILLEGAL_TRAP_EN to make opcodes B-E trap into HALT instead of executing as NOP.
module acc_ctrl_fsm #(
    parameter int OPC_W = 4,
    parameter int PC_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic             zf,
    output logic [7:0]       cw,
    output logic             j,
    output logic             ir_ld,
    output logic             retire,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(4'h0);
    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h3);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h8);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h9);
    localparam logic [OPC_W-1:0] OP_JNZ = OPC_W'(4'hA);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t           state_reg, state_next;
    logic [15:0]      ir_reg;
    logic [CNT_W-1:0] icount_reg;
    logic [OPC_W-1:0] opc;

    logic is_alu, is_sta, is_jump, is_hlt, is_bad, jump_taken;
    logic alu_src_dec;
    logic [2:0] alu_op_dec;

    logic acc_ld, dm_we, alu_src, pc_ld, pc_inc;
    logic [2:0] alu_op;

    // Operand/target bits are consumed by the datapath from its own copy of the word.
    logic                  unused_ir_low;
    logic [PC_W-1:0]       unused_jump_target;
    assign unused_ir_low      = ^ir_reg[15-OPC_W:0];
    assign unused_jump_target = ir_reg[PC_W-1:0];

    assign opc = ir_reg[15 -: OPC_W];

    // Opcode classification, from the registered IR only
    always_comb begin
        is_alu      = 1'b0;
        is_sta      = 1'b0;
        is_jump     = 1'b0;
        is_hlt      = 1'b0;
        is_bad      = 1'b0;
        alu_src_dec = 1'b0;
        alu_op_dec  = ALU_PASS;
        case (opc)
            OP_NOP: ;
            OP_LDA: is_alu = 1'b1;
            OP_LDI: begin
                is_alu      = 1'b1;
                alu_src_dec = 1'b1;
            end
            OP_STA: is_sta = 1'b1;
            OP_ADD: begin
                is_alu     = 1'b1;
                alu_op_dec = ALU_ADD;
            end
            OP_SUB: begin
                is_alu     = 1'b1;
                alu_op_dec = ALU_SUB;
            end
            OP_AND: begin
                is_alu     = 1'b1;
                alu_op_dec = ALU_AND;
            end
            OP_OR: begin
                is_alu     = 1'b1;
                alu_op_dec = ALU_OR;
            end
            OP_JMP, OP_JZ, OP_JNZ: is_jump = 1'b1;
            OP_HLT: is_hlt = 1'b1;
            default: is_bad = 1'b1;
        endcase
    end

    // zf is the only live input that reaches cw, and only in EXEC of a jump
    assign jump_taken = (opc == OP_JMP) ||
                        ((opc == OP_JZ)  &&  zf) ||
                        ((opc == OP_JNZ) && !zf);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (is_hlt || (TRAP_EN && is_bad)) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC:   state_next = is_alu ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        acc_ld  = 1'b0;
        dm_we   = 1'b0;
        alu_src = 1'b0;
        alu_op  = ALU_PASS;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        retire  = 1'b0;
        halted  = 1'b0;
        case (state_reg)
            S_IDLE: ;
            S_FETCH: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_DECODE: retire = is_hlt;
            S_EXEC: begin
                if (is_alu) begin
                    alu_src = alu_src_dec;
                    alu_op  = alu_op_dec;
                end else if (is_sta) begin
                    dm_we  = 1'b1;
                    retire = 1'b1;
                end else if (is_jump) begin
                    pc_ld  = jump_taken;
                    retire = 1'b1;
                end else begin
                    retire = 1'b1;
                end
            end
            S_WB: begin
                acc_ld  = 1'b1;
                alu_src = alu_src_dec;
                alu_op  = alu_op_dec;
                retire  = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign cw    = {acc_ld, dm_we, alu_src, alu_op, pc_ld, pc_inc};
    assign j     = pc_ld;
    assign state = state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_reg     <= '0;
            icount_reg <= '0;
        end else begin
            if (state_reg == S_FETCH) begin
                ir_reg <= instr;
            end
            if (retire) begin
                icount_reg <= icount_reg + CNT_W'(1);
            end
        end
    end

    assign icount = icount_reg;

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == S_DECODE && is_bad) begin
            illegal_reg <= 1'b1;
        end
    end

    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Self-checking bench for acc_ctrl_fsm: per-cycle traces compared against an instruction-level model.
module tb_acc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        zf = 1'b0;
    logic [7:0]  cw;
    logic        j, ir_ld, retire, halted, illegal;
    logic [2:0]  state;
    logic [15:0] icount;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_icount = 0;

    // Expected and observed per-cycle traces of one instruction
    logic [2:0] exp_state [8];
    logic [7:0] exp_cw    [8];
    logic       exp_ret   [8];
    logic       exp_irld  [8];
    int         exp_n;
    logic [2:0] obs_state [8];
    logic [7:0] obs_cw    [8];
    logic       obs_ret   [8];
    logic       obs_irld  [8];
    logic       obs_halt  [8];
    logic       obs_j     [8];

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    acc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .instr(instr), .zf(zf),
        .cw(cw), .j(j), .ir_ld(ir_ld), .retire(retire), .halted(halted),
        .illegal(illegal), .state(state), .icount(icount)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_word(input logic [3:0] op);
        case (op)
            4'h2:    return 8'h20;
            4'h4:    return 8'h04;
            4'h5:    return 8'h08;
            4'h6:    return 8'h0C;
            4'h7:    return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    task automatic set_cyc(input int k, input logic [2:0] s, input logic [7:0] c, input logic r, input logic il);
        exp_state[k] = s;
        exp_cw[k]    = c;
        exp_ret[k]   = r;
        exp_irld[k]  = il;
    endtask

    task automatic model_instr(input logic [15:0] ins, input logic z);
        logic [3:0] op;
        op = ins[15:12];
        set_cyc(0, 3'd1, 8'h01, 1'b0, 1'b1);
        set_cyc(1, 3'd2, 8'h00, op == 4'hF, 1'b0);
        if (op == 4'hF || (TRAP && op >= 4'hB && op <= 4'hE)) begin
            exp_n = 2;
        end else if (op == 4'h1 || op == 4'h2 || (op >= 4'h4 && op <= 4'h7)) begin
            set_cyc(2, 3'd3, alu_word(op), 1'b0, 1'b0);
            set_cyc(3, 3'd4, alu_word(op) | 8'h80, 1'b1, 1'b0);
            exp_n = 4;
        end else if (op == 4'h3) begin
            set_cyc(2, 3'd3, 8'h40, 1'b1, 1'b0);
            exp_n = 3;
        end else begin
            set_cyc(2, 3'd3, ((op == 4'h8) || (op == 4'h9 && z) || (op == 4'hA && !z)) ? 8'h02 : 8'h00, 1'b1, 1'b0);
            exp_n = 3;
        end
    endtask

    // Enters in FETCH (#1 after an edge); leaves #1 after the edge ending the last modelled cycle.
    task automatic capture_instr(input logic [15:0] ins, input logic z, input int n);
        for (int k = 0; k < n; k++) begin
            instr = (k == 0) ? ins : 16'($urandom);
            zf    = z;
            #1;
            obs_state[k] = state;
            obs_cw[k]    = cw;
            obs_ret[k]   = retire;
            obs_irld[k]  = ir_ld;
            obs_halt[k]  = halted;
            obs_j[k]     = j;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < n; k++) exp_icount = (exp_icount + int'(exp_ret[k])) % 65536;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_icount = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({state, cw, icount, illegal, ir_ld} !== {3'd0, 8'h00, 16'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold: got state=%0d cw=%h icount=%0d illegal=%b ir_ld=%b, need 0/00/0/0/0", state, cw, icount, illegal, ir_ld);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({state, cw, retire, halted} !== {3'd0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: got state=%0d cw=%h retire=%b halted=%b, need 0/00/0/0", state, cw, retire, halted);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({state, cw, ir_ld} !== {3'd1, 8'h01, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_fetch: got state=%0d cw=%h ir_ld=%b, need 1/01/1", state, cw, ir_ld);
        end
        exp_icount = 0;
        $display("reset: checked hold, idle and first fetch");
    endtask

    task automatic test_instr(input string name, input logic [15:0] ins, input logic z);
        model_instr(ins, z);
        capture_instr(ins, z, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            n_checks++;
            if ({obs_state[k], obs_cw[k], obs_ret[k], obs_irld[k], obs_halt[k], obs_j[k]} !==
                {exp_state[k], exp_cw[k], exp_ret[k], exp_irld[k], 1'b0, exp_cw[k][1]}) begin
                n_fail++;
                $display("FAIL %s cyc%0d: got state=%0d cw=%h ret=%b ir_ld=%b halt=%b j=%b, need state=%0d cw=%h ret=%b ir_ld=%b halt=0 j=%b",
                         name, k, obs_state[k], obs_cw[k], obs_ret[k], obs_irld[k], obs_halt[k], obs_j[k],
                         exp_state[k], exp_cw[k], exp_ret[k], exp_irld[k], exp_cw[k][1]);
            end
        end
        n_checks++;
        if (int'(icount) !== exp_icount) begin
            n_fail++;
            $display("FAIL %s icount: got %0d, need %0d", name, icount, exp_icount);
        end
        $display("instr %s %h zf=%b: %0d cycles, icount=%0d", name, ins, z, exp_n, icount);
    endtask

    task automatic test_ldi;
        test_instr("ldi", 16'h2005, 1'b0);
    endtask

    task automatic test_back_to_back;
        test_instr("add", 16'h4003, 1'b0);
        test_instr("sta", 16'h3004, 1'b1);
        n_checks++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_next_fetch: got state=%0d, need 1", state);
        end
    endtask

    task automatic test_jumps;
        test_instr("jz_taken", 16'h9012, 1'b1);
        test_instr("jz_not", 16'h9012, 1'b0);
        test_instr("jnz_taken", 16'hA007, 1'b0);
        test_instr("jnz_not", 16'hA007, 1'b1);
        test_instr("jmp", 16'h8011, 1'b0);
    endtask

    task automatic test_halt;
        test_instr("hlt", 16'hF000, 1'b0);
        for (int c = 0; c < 20; c++) begin
            instr = 16'($urandom);
            zf    = 1'($urandom);
            #1;
            n_checks++;
            if ({state, halted, cw, retire, ir_ld, j} !== {3'd5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0} || int'(icount) !== exp_icount) begin
                n_fail++;
                $display("FAIL halt_hold%0d: got state=%0d halted=%b cw=%h ret=%b icount=%0d, need 5/1/00/0/%0d",
                         c, state, halted, cw, retire, icount, exp_icount);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({state, halted, icount} !== {3'd0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL halt_reset: got state=%0d halted=%b icount=%0d, need 0/0/0", state, halted, icount);
        end
        @(posedge clk); #1;
        exp_icount = 0;
        $display("halt: held 20 cycles, reset to idle");
    endtask

    task automatic test_illegal;
        test_instr("illegal", 16'hC000, 1'b1);
        n_checks++;
        if (TRAP) begin
            if ({state, illegal, halted} !== {3'd5, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL illegal_trap: got state=%0d illegal=%b halted=%b, need 5/1/1", state, illegal, halted);
            end
        end else begin
            if ({state, illegal} !== {3'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL illegal_nop: got state=%0d illegal=%b, need 1/0", state, illegal);
            end
        end
        do_reset();
        n_checks++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clear: got %b, need 0", illegal);
        end
    endtask

    task automatic test_random;
        logic [3:0] op;
        for (int t = 0; t < 150; t++) begin
            op = 4'($urandom_range(0, TRAP ? 10 : 14));
            test_instr("rand", {op, 12'($urandom)}, 1'($urandom));
        end
    endtask

    initial begin
        fork
            begin
                #2000000;
                $display("FAIL timeout: simulation exceeded time budget");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_ldi();
        test_back_to_back();
        test_jumps();
        test_illegal();
        test_random();
        test_halt();
        test_ldi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
